// File: rtl/seg_page_sched.sv
// rtl/seg_page_sched.sv - picks the debug-word half or a timed message for the four BCD digits
module seg_page_sched #(
  parameter int HOLD_CYCLES = 50_000_000,
  parameter int MSG_CYCLES  = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word,
  input  logic        auto,
  input  logic        page_btn,
  input  logic        msg_valid,
  input  logic [15:0] msg_data,
  output logic        msg_ready,
  output logic [3:0]  bcd0,
  output logic [3:0]  bcd1,
  output logic [3:0]  bcd2,
  output logic [3:0]  bcd3,
  output logic        page,
  output logic        msg_active
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int MW = (MSG_CYCLES > 1) ? $clog2(MSG_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [MW-1:0] MSG_LAST  = MW'(MSG_CYCLES - 1);

  typedef enum logic [1:0] {SHOW_LO, SHOW_HI, SHOW_MSG} state_t;

  state_t        state_q, state_d;
  logic          page_q, page_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [MW-1:0] msg_cnt, msg_cnt_d;
  logic [15:0]   msg_q;
  logic [15:0]   bcd_q, bcd_d;
  logic          accept;

  assign accept = msg_valid && msg_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SHOW_LO;
      page_q   <= 1'b0;
      hold_cnt <= '0;
      msg_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      hold_cnt <= hold_d;
      msg_cnt  <= msg_cnt_d;
    end
  end

  // Message accept pre-empts rollover, which pre-empts the button; losers are dropped.
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    hold_d    = '0;
    msg_cnt_d = '0;
    case (state_q)
      SHOW_LO, SHOW_HI: begin
        if (accept) begin
          state_d = SHOW_MSG;
        end else if (auto) begin
          if (hold_cnt == HOLD_LAST) begin
            page_d  = ~page_q;
            state_d = page_q ? SHOW_LO : SHOW_HI;
          end else begin
            hold_d = hold_cnt + HW'(1);
          end
        end else if (page_btn) begin
          page_d  = ~page_q;
          state_d = page_q ? SHOW_LO : SHOW_HI;
        end
      end
      SHOW_MSG: begin
        if (msg_cnt == MSG_LAST) begin
          state_d = page_q ? SHOW_HI : SHOW_LO;
        end else begin
          msg_cnt_d = msg_cnt + MW'(1);
        end
      end
      default: begin
        state_d = SHOW_LO;
        page_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    msg_ready  = (state_q != SHOW_MSG);
    msg_active = (state_q == SHOW_MSG);
    page       = page_q;
  end

  // Digits follow the state being entered, so new data shows one edge after sampling.
  always_comb begin
    case (state_d)
      SHOW_HI:  bcd_d = word[31:16];
      SHOW_MSG: bcd_d = accept ? msg_data : msg_q;
      default:  bcd_d = word[15:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      msg_q <= '0;
      bcd_q <= '0;
    end else begin
      if (accept) begin
        msg_q <= msg_data;
      end
      bcd_q <= bcd_d;
    end
  end

  assign bcd0 = bcd_q[3:0];
  assign bcd1 = bcd_q[7:4];
  assign bcd2 = bcd_q[11:8];
  assign bcd3 = bcd_q[15:12];

endmodule

// File: tb/tb_seg_page_sched.sv
// tb/tb_seg_page_sched.sv - directed and randomized checks of seg_page_sched against a dwell-time model
module tb_seg_page_sched;

  localparam int HOLD = 4;
  localparam int MSG  = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] word = 32'h0;
  logic        auto = 1'b1;
  logic        page_btn = 1'b0;
  logic        msg_valid = 1'b0;
  logic [15:0] msg_data = 16'h0;
  logic        msg_ready;
  logic [3:0]  bcd0, bcd1, bcd2, bcd3;
  logic        page;
  logic        msg_active;

  always #5 clk = ~clk;

  seg_page_sched #(.HOLD_CYCLES(HOLD), .MSG_CYCLES(MSG)) dut (
    .clk(clk), .reset(reset), .word(word), .auto(auto), .page_btn(page_btn),
    .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3),
    .page(page), .msg_active(msg_active)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int xfer_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model: what is visible, and how many cycles it has been visible.
  bit          m_ok = 0;
  bit          m_in_msg, m_page;
  int          m_left, m_shown;
  logic [15:0] m_msg, m_bcd;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_ok = 1; m_in_msg = 0; m_page = 0; m_left = 0; m_shown = 1; m_msg = 0; m_bcd = 0;
    end else begin
      if (m_in_msg) begin
        m_left--;
        if (m_left == 0) begin
          m_in_msg = 0;
          m_shown = 1;
        end
      end else if (msg_valid) begin
        m_in_msg = 1; m_left = MSG; m_msg = msg_data;
      end else if (auto) begin
        if (m_shown == HOLD) begin
          m_page = !m_page;
          m_shown = 1;
        end else begin
          m_shown++;
        end
      end else begin
        m_shown = 1;
        if (page_btn) m_page = !m_page;
      end
      m_bcd = m_in_msg ? m_msg : (m_page ? word[31:16] : word[15:0]);
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("bcd", {16'h0, bcd3, bcd2, bcd1, bcd0}, {16'h0, m_bcd});
      check("page", {31'h0, page}, {31'h0, m_page});
      check("msg_active", {31'h0, msg_active}, {31'h0, m_in_msg});
      check("msg_ready", {31'h0, msg_ready}, {31'h0, !m_in_msg});
    end
    if (msg_valid && msg_ready && !reset) xfer_cyc.push_back(cyc + 1);
  end

  task automatic lit(input string name, input logic [15:0] b, input bit pg, input bit act);
    check({name, "_bcd"}, {16'h0, bcd3, bcd2, bcd1, bcd0}, {16'h0, b});
    check({name, "_page"}, {31'h0, page}, {31'h0, pg});
    check({name, "_active"}, {31'h0, msg_active}, {31'h0, act});
    check({name, "_ready"}, {31'h0, msg_ready}, {31'h0, !act});
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    bit acc;
    word = 32'h1234ABCD;
    edges(2);
    reset = 1'b0;
    @(negedge clk); lit("reset", 16'h0000, 0, 0);
    edges(1); @(negedge clk); lit("auto_lo", 16'hABCD, 0, 0);
    edges(3); @(negedge clk); lit("auto_hi", 16'h1234, 1, 0);
    edges(3); @(negedge clk); lit("auto_hi_dwell", 16'h1234, 1, 0);
    edges(1); @(negedge clk); lit("auto_lo_again", 16'hABCD, 0, 0);

    auto = 1'b0;
    edges(1);
    page_btn = 1'b1;
    edges(1);
    page_btn = 1'b0;
    @(negedge clk); lit("btn_hi", 16'h1234, 1, 0);
    edges(5); @(negedge clk); lit("btn_hold", 16'h1234, 1, 0);

    auto = 1'b1; msg_valid = 1'b1; msg_data = 16'hE001;
    edges(1);
    msg_valid = 1'b0;
    @(negedge clk); lit("msg_first", 16'hE001, 1, 1);
    edges(5); @(negedge clk); lit("msg_last", 16'hE001, 1, 1);
    edges(1); @(negedge clk); lit("msg_return_hi", 16'h1234, 1, 0);
    edges(3); @(negedge clk); lit("msg_hi_dwell", 16'h1234, 1, 0);
    edges(1); @(negedge clk); lit("msg_then_lo", 16'hABCD, 0, 0);

    edges(3);
    msg_valid = 1'b1; msg_data = 16'h5A5A;
    edges(1);
    msg_valid = 1'b0;
    @(negedge clk); lit("coincide_msg", 16'h5A5A, 0, 1);
    edges(6); @(negedge clk); lit("coincide_back_lo", 16'hABCD, 0, 0);

    msg_valid = 1'b1; msg_data = 16'h7777;
    edges(1);
    msg_valid = 1'b0;
    edges(2);
    reset = 1'b1;
    edges(1);
    @(negedge clk); lit("reset_mid_msg", 16'h0000, 0, 0);
    reset = 1'b0;
    edges(3);

    xfer_cyc.delete();
    msg_valid = 1'b1; msg_data = 16'h0F0F;
    edges(30);
    msg_valid = 1'b0;
    edges(8);
    checks++;
    if (xfer_cyc.size() < 4) begin
      errors++;
      $display("FAIL burst_count: got %0d transfers expected at least 4", xfer_cyc.size());
    end
    for (int i = 1; i < xfer_cyc.size(); i++)
      check("burst_spacing", xfer_cyc[i] - xfer_cyc[i-1], 7);

    for (int i = 0; i < 3000; i++) begin
      word = $urandom;
      if ($urandom_range(0, 39) == 0) auto = !auto;
      page_btn = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      if (!msg_valid && $urandom_range(0, 14) == 0) begin
        msg_valid = 1'b1;
        msg_data = 16'($urandom);
      end
      @(negedge clk);
      acc = msg_valid && msg_ready && !reset;
      edges(1);
      if (acc) msg_valid = 1'b0;
    end
    reset = 1'b0;
    edges(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
